// File: rtl/code_lock_if.sv
// Keypad/timebase bundle for code_lock.
// master: keypad/prescaler side driving keys and ticks, observing lock status.
// slave : the lock itself.
interface code_lock_if;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       key_set;
  logic       tick;
  logic [2:0] state;
  logic [4:0] pos;
  logic [2:0] tries;
  logic       unlocked;
  logic       alarm;
  logic       err;

  modport master (
    output key_valid, key_digit, key_set, tick,
    input  state, pos, tries, unlocked, alarm, err
  );

  modport slave (
    input  key_valid, key_digit, key_set, tick,
    output state, pos, tries, unlocked, alarm, err
  );
endinterface

// File: rtl/code_lock.sv
// code_lock: programmable digit-code lock with try counter and terminal alarm.
// Optional feature: define CODE_LOCK_LOCKOUT_EN to add a tick-timed LOCKOUT
// state after each non-alarm mismatch; without it a mismatch rearms at once
// and tick is unused.
module code_lock #(
  parameter int LEN           = 4,
  parameter int MAX_TRIES     = 3,
  parameter int LOCKOUT_TICKS = 8
) (
  input logic        clk,
  input logic        rst,
  code_lock_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PROGRAM = 3'd1,
    ARMED   = 3'd2,
    OPEN    = 3'd3,
`ifdef CODE_LOCK_LOCKOUT_EN
    LOCKOUT = 3'd4,
`endif
    ALARM   = 3'd5
  } state_t;

  localparam int          IW        = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int unsigned NDIG      = LEN;
  localparam logic [4:0]  LAST      = 5'(LEN - 1);
  localparam logic [2:0]  TRY_LIMIT = 3'(MAX_TRIES);

  state_t        st, st_n;
  logic [4:0]    pos, pos_n;
  logic [2:0]    tries, tries_n;
  logic          err_q, err_n;
  logic          unlocked_q, alarm_q;
  logic [3:0]    code [LEN];
  logic          code_we;
  logic [IW-1:0] idx;
  logic [3:0]    cur_digit;
  logic          key_cmd, key_dig, match;

`ifdef CODE_LOCK_LOCKOUT_EN
  localparam logic [7:0] TICK_LIMIT = 8'(LOCKOUT_TICKS);
  logic [7:0] lock_cnt, lock_cnt_n;
`endif

  assign idx       = pos[IW-1:0];
  assign cur_digit = code[idx];
  assign key_cmd   = bus.key_valid & bus.key_set;
  assign key_dig   = bus.key_valid & ~bus.key_set;
  assign match     = (bus.key_digit == cur_digit);

  // State register and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= IDLE;
      pos        <= '0;
      tries      <= '0;
      err_q      <= 1'b0;
      unlocked_q <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      st         <= st_n;
      pos        <= pos_n;
      tries      <= tries_n;
      err_q      <= err_n;
      unlocked_q <= (st_n == OPEN);
      alarm_q    <= (st_n == ALARM);
    end
  end

  // Code storage, written one digit at a time while programming.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NDIG; i++) begin
        code[i] <= '0;
      end
    end else if (code_we) begin
      code[idx] <= bus.key_digit;
    end
  end

`ifdef CODE_LOCK_LOCKOUT_EN
  // Lockout tick counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_cnt <= '0;
    end else begin
      lock_cnt <= lock_cnt_n;
    end
  end
`endif

  // Next-state, position, try count and error pulse.
  always_comb begin
    st_n    = st;
    pos_n   = pos;
    tries_n = tries;
    err_n   = 1'b0;
    code_we = 1'b0;
`ifdef CODE_LOCK_LOCKOUT_EN
    lock_cnt_n = lock_cnt;
`endif

    case (st)
      IDLE: begin
        if (key_cmd) begin
          st_n  = PROGRAM;
          pos_n = '0;
        end
      end

      PROGRAM: begin
        if (key_cmd) begin
          pos_n = '0;
        end else if (key_dig) begin
          code_we = 1'b1;
          if (pos == LAST) begin
            st_n    = ARMED;
            pos_n   = '0;
            tries_n = '0;
          end else begin
            pos_n = pos + 5'd1;
          end
        end
      end

      ARMED: begin
        if (key_cmd) begin
          pos_n = '0;
        end else if (key_dig) begin
          if (match) begin
            if (pos == LAST) begin
              st_n    = OPEN;
              pos_n   = '0;
              tries_n = '0;
            end else begin
              pos_n = pos + 5'd1;
            end
          end else begin
            err_n = 1'b1;
            if (tries < TRY_LIMIT) begin
              tries_n = tries + 3'd1;
            end
            if (tries_n == TRY_LIMIT) begin
              st_n = ALARM;
            end else begin
              pos_n = '0;
`ifdef CODE_LOCK_LOCKOUT_EN
              st_n       = LOCKOUT;
              lock_cnt_n = '0;
`else
              st_n = ARMED;
`endif
            end
          end
        end
      end

      OPEN: begin
        if (key_cmd) begin
          st_n  = ARMED;
          pos_n = '0;
        end
      end

`ifdef CODE_LOCK_LOCKOUT_EN
      // Keys are dropped here, including one that lands with a tick.
      LOCKOUT: begin
        if (bus.tick) begin
          lock_cnt_n = lock_cnt + 8'd1;
          if (lock_cnt_n == TICK_LIMIT) begin
            st_n  = ARMED;
            pos_n = '0;
          end
        end
      end
`endif

      ALARM: begin
        st_n = ALARM;
      end

      default: begin
        st_n  = IDLE;
        pos_n = '0;
      end
    endcase
  end

  assign bus.state    = st;
  assign bus.pos      = pos;
  assign bus.tries    = tries;
  assign bus.unlocked = unlocked_q;
  assign bus.alarm    = alarm_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_code_lock.sv
// Testbench for code_lock: directed scenarios plus randomized keys/ticks,
// checked every cycle against a behavioural model of the lock rules.
module tb_code_lock;
  localparam int LEN    = 4;
  localparam int MAXT   = 3;
  localparam int LTICKS = 2;
`ifdef CODE_LOCK_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  code_lock_if bus ();

  code_lock #(
    .LEN(LEN),
    .MAX_TRIES(MAXT),
    .LOCKOUT_TICKS(LTICKS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Behavioural model: state numbers as the lock reports them.
  int m_state, m_pos, m_tries, m_cnt;
  bit m_err;
  int m_code [LEN];

  task automatic expect_eq(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_pos = 0; m_tries = 0; m_cnt = 0; m_err = 1'b0;
    for (int i = 0; i < LEN; i++) m_code[i] = 0;
  endtask

  task automatic model_step(input bit r, input bit kv, input int kd, input bit ks, input bit tk);
    if (r) begin
      model_reset();
      return;
    end
    m_err = 1'b0;
    if (m_state == 0) begin
      if (kv && ks) begin m_state = 1; m_pos = 0; end
    end else if (m_state == 1) begin
      if (kv && ks) m_pos = 0;
      else if (kv) begin
        m_code[m_pos] = kd;
        m_pos++;
        if (m_pos == LEN) begin m_state = 2; m_pos = 0; m_tries = 0; end
      end
    end else if (m_state == 2) begin
      if (kv && ks) m_pos = 0;
      else if (kv && kd == m_code[m_pos]) begin
        m_pos++;
        if (m_pos == LEN) begin m_state = 3; m_pos = 0; m_tries = 0; end
      end else if (kv) begin
        m_err = 1'b1;
        m_tries = (m_tries < MAXT) ? m_tries + 1 : MAXT;
        if (m_tries == MAXT) m_state = 5;
        else begin
          m_pos = 0;
          m_cnt = 0;
          m_state = LOCK_EN ? 4 : 2;
        end
      end
    end else if (m_state == 3) begin
      if (kv && ks) begin m_state = 2; m_pos = 0; end
    end else if (m_state == 4) begin
      if (tk) begin
        m_cnt++;
        if (m_cnt == LTICKS) begin m_state = 2; m_pos = 0; end
      end
    end
  endtask

  // Drive one cycle of stimulus, advance the model on the sampling edge.
  task automatic cyc(input bit r, input bit kv, input int kd, input bit ks, input bit tk);
    rst = r;
    bus.key_valid = kv;
    bus.key_digit = 4'(kd);
    bus.key_set = ks;
    bus.tick = tk;
    if (r) model_reset();
    @(posedge clk);
    model_step(r, kv, kd, ks, tk);
    #1;
  endtask

  task automatic press(input int d);  cyc(1'b0, 1'b1, d, 1'b0, 1'b0); endtask
  task automatic setkey();            cyc(1'b0, 1'b1, 0, 1'b1, 1'b0); endtask
  task automatic tick1();             cyc(1'b0, 1'b0, 0, 1'b0, 1'b1); endtask
  task automatic idle();              cyc(1'b0, 1'b0, 0, 1'b0, 1'b0); endtask
  task automatic do_reset();
    cyc(1'b1, 1'b0, 0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 0, 1'b0, 1'b0);
    idle();
  endtask

  task automatic check_outs(input string tag, input int st, input int p, input int tr,
                            input bit ul, input bit al, input bit er);
    expect_eq({tag, "_state"}, bus.state, 8'(st));
    expect_eq({tag, "_pos"}, bus.pos, 8'(p));
    expect_eq({tag, "_tries"}, bus.tries, 8'(tr));
    expect_eq({tag, "_unlocked"}, 8'(bus.unlocked), 8'(ul));
    expect_eq({tag, "_alarm"}, 8'(bus.alarm), 8'(al));
    expect_eq({tag, "_err"}, 8'(bus.err), 8'(er));
  endtask

  // Every-cycle comparison of the lock against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      expect_eq("cyc_state", bus.state, 8'(m_state));
      expect_eq("cyc_pos", bus.pos, 8'(m_pos));
      expect_eq("cyc_tries", bus.tries, 8'(m_tries));
      expect_eq("cyc_unlocked", 8'(bus.unlocked), 8'(m_state == 3));
      expect_eq("cyc_alarm", 8'(bus.alarm), 8'(m_state == 5));
      expect_eq("cyc_err", 8'(bus.err), 8'(m_err));
    end
  end

  initial begin
    rst = 1'b1;
    bus.key_valid = 1'b0; bus.key_digit = '0; bus.key_set = 1'b0; bus.tick = 1'b0;
    model_reset();
    chk_en = 1'b1;
    do_reset();
    check_outs("reset", 0, 0, 0, 1'b0, 1'b0, 1'b0);

    // Program 1,2,3,4 then open.
    setkey();
    check_outs("set_idle", 1, 0, 0, 1'b0, 1'b0, 1'b0);
    for (int d = 1; d <= 4; d++) press(d);
    check_outs("programmed", 2, 0, 0, 1'b0, 1'b0, 1'b0);
    expect_eq("model_programmed", 8'(m_state), 8'd2);
    for (int d = 1; d <= 4; d++) press(d);
    check_outs("opened", 3, 0, 0, 1'b1, 1'b0, 1'b0);
    press(7);
    check_outs("open_digit_ignored", 3, 0, 0, 1'b1, 1'b0, 1'b0);

    // Relock and discard a partial entry.
    setkey();
    check_outs("relock", 2, 0, 0, 1'b0, 1'b0, 1'b0);
    press(1);
    check_outs("partial1", 2, 1, 0, 1'b0, 1'b0, 1'b0);
    press(2);
    check_outs("partial2", 2, 2, 0, 1'b0, 1'b0, 1'b0);
    setkey();
    check_outs("partial_clear", 2, 0, 0, 1'b0, 1'b0, 1'b0);

    // First mismatch.
    press(9);
    if (LOCK_EN) begin
      check_outs("mismatch1", 4, 0, 1, 1'b0, 1'b0, 1'b1);
      press(1);
      check_outs("lockout_key", 4, 0, 1, 1'b0, 1'b0, 1'b0);
      tick1();
      check_outs("lockout_tick1", 4, 0, 1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1, 1'b0, 1'b1);
      check_outs("lockout_tick2", 2, 0, 1, 1'b0, 1'b0, 1'b0);
    end else begin
      check_outs("mismatch1", 2, 0, 1, 1'b0, 1'b0, 1'b1);
      tick1();
      check_outs("tick_unused", 2, 0, 1, 1'b0, 1'b0, 1'b0);
    end

    // Second and third mismatches reach alarm.
    press(9);
    expect_eq("mismatch2_tries", bus.tries, 8'd2);
    expect_eq("mismatch2_err", 8'(bus.err), 8'd1);
    tick1(); tick1();
    expect_eq("rearm2_state", bus.state, 8'd2);
    press(9);
    expect_eq("alarm_state", bus.state, 8'd5);
    expect_eq("alarm_flag", 8'(bus.alarm), 8'd1);
    expect_eq("alarm_tries", bus.tries, 8'd3);
    expect_eq("model_alarm", 8'(m_state), 8'd5);
    for (int d = 1; d <= 4; d++) press(d);
    tick1(); setkey(); tick1();
    expect_eq("alarm_sticky", bus.state, 8'd5);
    do_reset();
    check_outs("alarm_reset", 0, 0, 0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of programming, then program afresh.
    setkey(); press(5); press(6);
    expect_eq("midprog_pos", bus.pos, 8'd2);
    do_reset();
    check_outs("midprog_reset", 0, 0, 0, 1'b0, 1'b0, 1'b0);
    setkey();
    for (int d = 6; d <= 9; d++) press(d);
    check_outs("reprogram", 2, 0, 0, 1'b0, 1'b0, 1'b0);
    for (int d = 6; d <= 9; d++) press(d);
    expect_eq("reprogram_open", bus.state, 8'd3);

    // Randomized keys, ticks and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      bit r, kv, ks, tk;
      int kd;
      r  = ($urandom_range(0, 299) == 0);
      kv = ($urandom_range(0, 9) < 4);
      ks = ($urandom_range(0, 9) == 0);
      tk = ($urandom_range(0, 9) < 2);
      kd = ($urandom_range(0, 9) < 9) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 15));
      cyc(r, kv, kd, ks, tk);
    end

    idle();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/code_lock.md
CODE_LOCK -- requirements
Module: code_lock

Interface
REQ-001 Parameter LEN, 4: code length in digits, legal 2..16.
REQ-002 Parameter MAX_TRIES, 3: failed attempts that trigger ALARM, legal 1..7.
REQ-003 Parameter LOCKOUT_TICKS, 8: tick pulses spent in LOCKOUT, legal 1..255.
REQ-004 clk  in  1  clock; every state element updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 key_valid  in  1  one-cycle strobe, one per keypress.
REQ-007 key_digit  in  4  hex digit 0..15; sampled only when key_valid=1.
REQ-008 key_set  in  1  command key; sampled only when key_valid=1; when 1, key_digit is ignored.
REQ-009 tick  in  1  one-cycle timebase pulse from the prescaler.
REQ-010 state  out  3  encoding IDLE=0, PROGRAM=1, ARMED=2, OPEN=3, LOCKOUT=4, ALARM=5; values 6 and 7 are unused.
REQ-011 pos  out  5  current digit index, 0..LEN-1.
REQ-012 tries  out  3  failed attempts since the last OPEN or PROGRAM completion.
REQ-013 unlocked  out  1  high exactly when state=OPEN.
REQ-014 alarm  out  1  high exactly when state=ALARM.
REQ-015 err  out  1  one-cycle pulse on each digit mismatch.

Function
REQ-016 All outputs are registered; every response appears on the edge that samples the causing key_valid or tick (latency 1 cycle).
REQ-017 Code storage: LEN x 4-bit registers, written only in PROGRAM.
REQ-018 IDLE: key_set -> PROGRAM with pos=0; digits are ignored.
REQ-019 PROGRAM: each digit writes code[pos] and increments pos; the digit at pos=LEN-1 -> ARMED with pos=0 and tries=0; key_set restarts the entry with pos=0.
REQ-020 ARMED match (digit == code[pos]): pos increments; a match at pos=LEN-1 -> OPEN with pos=0 and tries=0.
REQ-021 ARMED mismatch: err=1 and tries increments; if the new tries value equals MAX_TRIES -> ALARM; otherwise -> LOCKOUT (REQ-027) with pos=0.
REQ-022 ARMED key_set: pos=0 (partial entry discarded); tries unchanged; no err pulse.
REQ-023 OPEN: key_set -> ARMED with pos=0 and the code retained; digits are ignored.
REQ-024 ALARM: terminal; every key and tick is ignored; only rst exits.
REQ-025 key_valid in a state or case not listed above: no state or output change.
REQ-026 pos never exceeds LEN-1; tries saturates at MAX_TRIES.

Configuration
REQ-027 Macro CODE_LOCK_LOCKOUT_EN defined: a non-alarm mismatch -> LOCKOUT; the counter clears on entry; keys are ignored; each tick increments the counter; the edge sampling tick LOCKOUT_TICKS -> ARMED with pos=0; a tick coinciding with key_valid is counted and the key is dropped.
REQ-028 Macro CODE_LOCK_LOCKOUT_EN undefined: a non-alarm mismatch -> ARMED with pos=0; the LOCKOUT state and counter are absent; state never equals 4; tick is unused.

Reset
REQ-029 rst=1, including mid-entry or mid-lockout: state=IDLE, pos=0, tries=0, unlocked=0, alarm=0, err=0, all code digits=0, lockout counter=0.
REQ-030 After rst deasserts, the first key_valid is processed normally on the next edge.

Verification (LEN=4, MAX_TRIES=3, LOCKOUT_TICKS=2, macro defined unless noted)
REQ-031 Program: set, 1, 2, 3, 4 -> state=2, pos=0, tries=0; then 1, 2, 3, 4 -> state=3, unlocked=1.
REQ-032 Relock and partial clear: from OPEN, set -> state=2; then 1, 2, set -> pos=0, tries=0, err never asserted.
REQ-033 Lockout: in ARMED, digit 9 -> err pulse, tries=1, state=4; keys during lockout ignored; second tick -> state=2, pos=0.
REQ-034 Alarm: three mismatched attempts (lockouts served) -> state=5, alarm=1, tries=3; the correct code afterwards -> state stays 5; rst -> state=0, all outputs 0.
REQ-035 Macro undefined: digit 9 in ARMED -> err pulse, state=2, pos=0, tries=1; state never equals 4.
REQ-036 Reset mid-PROGRAM after 2 digits -> state=0, code digits 0; a fresh set plus 4 digits programs normally.
